// File: rtl/obf_key_site_ctrl_pkg.sv
// obf_key_pkg: shared types for the obfuscation key-site controller.
// Site modes, controller states and the per-site mode function.
package obf_key_pkg;

    // Encoding is {odd D bit, even D bit} of the legacy key cells.
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b10,
        MODE_C1   = 2'b01,
        MODE_C0   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        ERR
    } state_e;

    function automatic logic site_apply(input logic b, input mode_e m);
        logic y;
        y = 1'b0;
        unique case (m)
            MODE_PASS: y = b;
            MODE_INV:  y = ~b;
            MODE_C1:   y = 1'b1;
            MODE_C0:   y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/obf_key_site_ctrl_site_cell.sv
// obf_site_cell: combinational 1-bit mode application for one site.
// Ports: sig (net in), mode (2-bit site mode), y (obfuscated net).
module obf_site_cell
    import obf_key_pkg::*;
(
    input  logic       sig,
    input  logic [1:0] mode,
    output logic       y
);

    assign y = site_apply(sig, mode_e'(mode));

endmodule

// File: rtl/obf_key_site_ctrl.sv
// obf_key_site_ctrl: serial key loader with atomic commit that applies
// per-site 2-bit modes (pass/invert/const1/const0) to N_SITES nets.
// Ports: clk, rst (async, active-high), sig_in/sig_out (registered),
// key_vld/key_bit/key_rdy (LSB-first serial key), key_abort,
// key_loaded, busy; key_err only with OBF_KEY_PARITY_EN.
// Macro OBF_KEY_PARITY_EN: load carries a trailing even-parity bit;
// a bad parity locks the block in ERR (all sites const0) until rst.
module obf_key_site_ctrl
    import obf_key_pkg::*;
#(
    parameter int         N_SITES    = 6,
    parameter logic [1:0] RESET_MODE = 2'b11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SITES-1:0] sig_in,
    output logic [N_SITES-1:0] sig_out,
    input  logic               key_vld,
    input  logic               key_bit,
    output logic               key_rdy,
    input  logic               key_abort,
    output logic               key_loaded,
    output logic               busy
`ifdef OBF_KEY_PARITY_EN
    ,
    output logic               key_err
`endif
);

    localparam int KEY_W = 2 * N_SITES;
`ifdef OBF_KEY_PARITY_EN
    localparam int LOAD_W = KEY_W + 1;
`else
    localparam int LOAD_W = KEY_W;
`endif
    localparam int CNT_W = $clog2(LOAD_W + 1);

    state_e             state_q;
    state_e             state_d;
    logic [LOAD_W-1:0]  shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [KEY_W-1:0]   key_q;
    logic               loaded_q;

    logic               xfer;
    logic               last;
    logic               shift_en;
    logic               clr;
    logic               commit;
    logic               force_c0;
    logic [1:0]         mode_w [N_SITES];
    logic [N_SITES-1:0] cell_y;

    assign xfer = key_vld && key_rdy;
    assign last = (cnt_q == CNT_W'(LOAD_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clr      = 1'b0;
        commit   = 1'b0;
        key_rdy  = 1'b1;
        busy     = 1'b0;
        force_c0 = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort is ignored here; a transfer always starts a load
                if (xfer) begin
                    shift_en = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (key_abort) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    shift_en = 1'b1;
                    if (last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                busy    = 1'b1;
                key_rdy = 1'b0;
                clr     = 1'b1;
`ifdef OBF_KEY_PARITY_EN
                if (^shift_q) begin
                    state_d = ERR;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
`else
                commit  = 1'b1;
                state_d = IDLE;
`endif
            end
`ifdef OBF_KEY_PARITY_EN
            ERR: begin
                key_rdy  = 1'b0;
                force_c0 = 1'b1;
            end
`else
            default: begin
                state_d = IDLE;
            end
`endif
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            key_q    <= {N_SITES{RESET_MODE}};
            loaded_q <= 1'b0;
            sig_out  <= '0;
        end else begin
            if (clr) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_en) begin
                // shift right so the first bit ends at bit 0
                shift_q <= {key_bit, shift_q[LOAD_W-1:1]};
                cnt_q   <= cnt_q + 1'b1;
            end
            if (commit) begin
                key_q    <= shift_q[KEY_W-1:0];
                loaded_q <= 1'b1;
            end
            sig_out <= cell_y;
        end
    end

    for (genvar i = 0; i < N_SITES; i++) begin : g_site
        assign mode_w[i] = force_c0 ? 2'(MODE_C0) : key_q[2*i +: 2];
        obf_site_cell u_cell (
            .sig  (sig_in[i]),
            .mode (mode_w[i]),
            .y    (cell_y[i])
        );
    end

    assign key_loaded = loaded_q;
`ifdef OBF_KEY_PARITY_EN
    assign key_err = (state_q == ERR);
`endif

endmodule

// File: tb/tb_obf_key_site_ctrl.sv
// tb_obf_key_site_ctrl: directed-vector bench for obf_key_site_ctrl.
// Key bit 0 is sent first; site i mode is {key[2i+1], key[2i]}.
module tb_obf_key_site_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sig_in = '0;
    logic [5:0] sig_out;
    logic       key_vld = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_rdy;
    logic       key_abort = 1'b0;
    logic       key_loaded;
    logic       busy;
`ifdef OBF_KEY_PARITY_EN
    logic       key_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obf_key_site_ctrl #(.N_SITES(6), .RESET_MODE(2'b11)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .key_vld    (key_vld),
        .key_bit    (key_bit),
        .key_rdy    (key_rdy),
        .key_abort  (key_abort),
        .key_loaded (key_loaded),
        .busy       (busy)
`ifdef OBF_KEY_PARITY_EN
        ,
        .key_err    (key_err)
`endif
    );

    task automatic drive_bit(input logic b);
        @(negedge clk);
        key_vld   = 1'b1;
        key_bit   = b;
        key_abort = 1'b0;
    endtask

    task automatic drive_bits(input logic [11:0] k, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive_bit(k[i]);
        end
    endtask

    // Ends on the negedge after the last transfer (state COMMIT).
    task automatic finish_load(input logic [11:0] k, input logic hold);
`ifdef OBF_KEY_PARITY_EN
        drive_bit(^k);
`endif
        @(negedge clk);
        key_vld = hold;
        key_bit = 1'b1;
    endtask

    task automatic test_reset();
        sig_in = 6'b101010;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b000000) begin
            n_err++;
            $display("FAIL rst_hold_sig_out got=%b exp=000000", sig_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b000000) begin
            n_err++;
            $display("FAIL rst_locked_sig_out got=%b exp=000000", sig_out);
        end
        n_vec++;
        if (key_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL rst_key_loaded got=%b exp=0", key_loaded);
        end
        n_vec++;
        if (key_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_key_rdy got=%b exp=1", key_rdy);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        sig_in = 6'b101010;
        drive_bits(12'h000, 0, 11);
        // keep key_vld high through COMMIT; it must be ignored
        finish_load(12'h000, 1'b1);
        n_vec++;
        if (key_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_commit_rdy got=%b exp=0", key_rdy);
        end
        n_vec++;
        if (sig_out !== 6'b000000) begin
            n_err++;
            $display("FAIL b2b_commit_sig_out got=%b exp=000000", sig_out);
        end
        @(negedge clk);
        key_vld = 1'b0;
        n_vec++;
        if (sig_out !== 6'b000000) begin
            n_err++;
            $display("FAIL b2b_atomic_sig_out got=%b exp=000000", sig_out);
        end
        n_vec++;
        if (key_loaded !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_key_loaded got=%b exp=1", key_loaded);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_vld_ignored_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b101010) begin
            n_err++;
            $display("FAIL b2b_pass_sig_out got=%b exp=101010", sig_out);
        end
    endtask

    task automatic test_invert_stall();
        sig_in = 6'b110011;
        drive_bits(12'hAAA, 0, 5);
        @(negedge clk);
        key_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (sig_out !== 6'b110011 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stall_%0d sig_out=%b busy=%b exp=110011/1",
                         i, sig_out, busy);
            end
            @(negedge clk);
        end
        drive_bits(12'hAAA, 6, 11);
        finish_load(12'hAAA, 1'b0);
        @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b110011) begin
            n_err++;
            $display("FAIL inv_old_key got=%b exp=110011", sig_out);
        end
        @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b001100) begin
            n_err++;
            $display("FAIL inv_sig_out got=%b exp=001100", sig_out);
        end
    endtask

    // Sites 5..0 = C0, C1, INV, PASS, C1, C0 -> key 12'hD87.
    task automatic test_mixed_modes();
        sig_in = 6'b111111;
        drive_bits(12'hD87, 0, 7);
        n_vec++;
        if (sig_out !== 6'b000000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mix_mid_load sig_out=%b busy=%b exp=000000/1",
                     sig_out, busy);
        end
        drive_bits(12'hD87, 8, 11);
        finish_load(12'hD87, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b010110) begin
            n_err++;
            $display("FAIL mix_ones got=%b exp=010110", sig_out);
        end
        sig_in = 6'b000000;
        @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b011010) begin
            n_err++;
            $display("FAIL mix_zeros got=%b exp=011010", sig_out);
        end
    endtask

    task automatic test_abort();
        drive_bits(12'hFFF, 0, 6);
        @(negedge clk);
        key_vld   = 1'b1;
        key_bit   = 1'b1;
        key_abort = 1'b1;
        @(negedge clk);
        key_vld   = 1'b0;
        key_abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || key_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL abort7 busy=%b rdy=%b exp=0/1", busy, key_rdy);
        end
        n_vec++;
        if (sig_out !== 6'b011010) begin
            n_err++;
            $display("FAIL abort7_sig_out got=%b exp=011010", sig_out);
        end
`ifdef OBF_KEY_PARITY_EN
        drive_bits(12'hFFF, 0, 11);
`else
        drive_bits(12'hFFF, 0, 10);
`endif
        @(negedge clk);
        key_vld   = 1'b1;
        key_bit   = 1'b1;
        key_abort = 1'b1;
        @(negedge clk);
        key_vld   = 1'b0;
        key_abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_last_busy got=%b exp=0", busy);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b011010) begin
            n_err++;
            $display("FAIL abort_last_sig_out got=%b exp=011010", sig_out);
        end
        sig_in = 6'b110101;
        // first bit arrives with abort high while IDLE
        @(negedge clk);
        key_vld   = 1'b1;
        key_bit   = 1'b0;
        key_abort = 1'b1;
        drive_bits(12'h000, 1, 11);
        finish_load(12'h000, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b110101) begin
            n_err++;
            $display("FAIL reload_after_abort got=%b exp=110101", sig_out);
        end
        n_vec++;
        if (key_loaded !== 1'b1) begin
            n_err++;
            $display("FAIL reload_key_loaded got=%b exp=1", key_loaded);
        end
    endtask

    task automatic test_reset_mid_load();
        drive_bits(12'h555, 0, 4);
        @(negedge clk);
        rst     = 1'b1;
        key_vld = 1'b0;
        #1;
        n_vec++;
        if (sig_out !== 6'b000000 || key_loaded !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid sig_out=%b loaded=%b busy=%b exp=000000/0/0",
                     sig_out, key_loaded, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b000000 || key_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_relock sig_out=%b rdy=%b exp=000000/1",
                     sig_out, key_rdy);
        end
        drive_bits(12'h000, 0, 11);
        finish_load(12'h000, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (sig_out !== 6'b110101) begin
            n_err++;
            $display("FAIL rst_mid_reload got=%b exp=110101", sig_out);
        end
    endtask

`ifdef OBF_KEY_PARITY_EN
    task automatic test_parity_err();
        sig_in = 6'b111111;
        drive_bits(12'h001, 0, 11);
        drive_bit(1'b0);
        @(negedge clk);
        key_vld = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (key_err !== 1'b1 || key_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL par_err err=%b rdy=%b exp=1/0", key_err, key_rdy);
        end
        n_vec++;
        if (sig_out !== 6'b000000) begin
            n_err++;
            $display("FAIL par_err_sig_out got=%b exp=000000", sig_out);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (key_err !== 1'b1 || key_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL par_err_hold err=%b rdy=%b exp=1/0", key_err, key_rdy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (key_err !== 1'b0 || key_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL par_err_rst err=%b rdy=%b exp=0/1", key_err, key_rdy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_invert_stall();
        test_mixed_modes();
        test_abort();
        test_reset_mid_load();
`ifdef OBF_KEY_PARITY_EN
        test_parity_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
